alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-port round-robin scheduler and sequencer for the shared 8-bit add/sub/max ALU in the SRA datapath. It accepts operation requests from two requesters and grants the ALU to one at a time. It drives the ALU's operand and select inputs, waits out the ALU's one-cycle input register, and captures the result. It then returns the result, with a signed-overflow flag computed from the latched operands, to the owning requester.

## Interface
- W, 8: operand/result width; fixed to 8 to match the ALU.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req0 / req1  in  1  request from port k; held high with op/a/b stable until gnt_k.
- op0 / op1  in  2  ALU select for port k: 00 add, 01 sub, 11 sub, 10 max-select.
- a0, b0 / a1, b1  in  W  operands for port k.
- gnt0 / gnt1  out  1  one-cycle pulse: request of port k accepted, operands latched.
- done0 / done1  out  1  one-cycle pulse: res_k/ovf_k updated for port k.
- res0 / res1  out  W  last result for port k; held until the next done_k.
- ovf0 / ovf1  out  1  signed overflow of last op for port k; held like res_k.
- busy  out  1  high in ISSUE and CAPTURE.
- alu_select  out  2  to ALU select.
- alu_a / alu_b  out  W  to ALU A/B.
- alu_result  in  W  ALU result, valid one cycle after select/A/B are presented.

## Operation
- FSM has three states: IDLE, ISSUE, CAPTURE. Reset state is IDLE.
- IDLE
  - If no req: stay.
  - If exactly one req_k: grant k.
  - If both: grant the port indicated by the priority pointer prio (reset 0).
  - On grant: latch op/a/b of k into op_q/a_q/b_q and owner <= k. Drive alu_select/alu_a/alu_b <= op/a/b of k (registered). Set gnt_k <= 1 and prio <= ~k. Go to ISSUE.
- ISSUE: ALU samples alu_* at the end of this cycle. Go to CAPTURE.
- CAPTURE: alu_result is valid. At the edge ending CAPTURE, res_owner <= alu_result, ovf_owner <= flag, done_owner <= 1. Go to IDLE.
- Overflow flag, with r = alu_result and sign bits a7 = a_q[7], b7 = b_q[7], r7 = r[7]:
  - op 00: (a7 == b7) && (r7 != a7).
  - op 01/11: (a7 != b7) && (r7 != a7).
  - op 10: overflow of a_q − b_q, i.e. (a7 != b7) && (a_q−b_q)[7] != a7, computed internally. This flags that the ALU's sign-based max decision is invalid. The result is still returned unmodified.
- Requests seen in ISSUE/CAPTURE are not sampled. They wait, held, until IDLE.
- alu_select/alu_a/alu_b hold their last value outside IDLE-grant.
- A request of the non-owner arriving during an op is served next even if the owner re-requests in the IDLE cycle, because the pointer was already toggled.
- Reset (rst_n = 0 at an edge) in any state, including mid-op:
  - FSM goes to IDLE and prio to 0.
  - gnt/done go to 0; res/ovf go to 0; alu_select goes to 00 and alu_a/alu_b to 0; busy goes to 0.
  - The in-flight operation is dropped with no done pulse.

## Timing
- All outputs are registered. Reset values are all zero.
- req_k high at edge n (state IDLE):
  - gnt_k high in cycle n+1 (ISSUE). busy is high in n+1..n+2.
  - done_k, res_k and ovf_k are valid in cycle n+3.
  - The FSM is in IDLE in n+3 and can grant again at the edge ending n+3.
- Peak throughput is one op per 3 cycles. With both ports requesting continuously, grants alternate 0,1,0,1…
- A requester may deassert req_k in the cycle after gnt_k. If req_k stays high, it is treated as a new request on the next IDLE.
- done_k and gnt_k are never high for both ports in the same cycle.

## Test plan
Bench uses an ALU model that registers select/A/B and computes the result combinationally from the registered values.
- Port 0 add, a0 = 0x05, b0 = 0x03, op0 = 00, req0 at edge 0 -> gnt0 in cycle 1, done0 in cycle 3, res0 = 0x08, ovf0 = 0, busy high in cycles 1–2 only.
- Port 1 sub, a1 = 0x80, b1 = 0x01, op1 = 01 -> res1 = 0x7F, ovf1 = 1. Then op1 = 11, a1 = 0x10, b1 = 0x20 -> res1 = 0xF0, ovf1 = 0.
- Max select:
  - a0 = 0x05, b0 = 0x09, op0 = 10 -> res0 = 0x09, ovf0 = 0.
  - a0 = 0x7F, b0 = 0x80 -> res0 = 0x80 (ALU decision on wrapped difference), ovf0 = 1.
- req0 and req1 both raised at edge 0 and held, with 0x01+0x01 on port 0 and 0x02+0x02 on port 1:
  - gnt0 in cycle 1, done0 in cycle 3 with 0x02.
  - gnt1 in cycle 4, done1 in cycle 6 with 0x04.
  - gnt0 in cycle 7. Never both gnts in one cycle.
- Reset mid-op: req1 accepted, rst_n low for one edge during CAPTURE -> no done1, res1 = 0x00, all outputs 0, state IDLE. A subsequent simultaneous req0/req1 is granted to port 0 first.
- Request held during busy: req1 raised in ISSUE of a port-0 op -> gnt1 exactly one cycle after done0 is sampled in IDLE. res0 is unchanged by the port-1 completion.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-port round-robin scheduler for a shared add/sub/max ALU with a one-cycle input register.
// Latches the winner's operands, issues them to the ALU, then returns the result and overflow flag.
module alu_share_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res0,
  output logic [W-1:0] res1,
  output logic         ovf0,
  output logic         ovf1,
  output logic         busy,
  output logic [1:0]   alu_select,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StIssue   = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;

  logic [1:0]   state_q;
  logic         prio_q;
  logic         owner_q;
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  logic         any_req;
  logic         sel;
  logic [1:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [W-1:0] diff;
  logic         a_sign;
  logic         b_sign;
  logic         r_sign;
  logic         ovf_flag;

  // Port 1 wins only if it is the sole requester or holds the priority pointer.
  always_comb begin
    any_req = req0 | req1;
    sel     = req1 & (~req0 | prio_q);
    sel_op  = sel ? op1 : op0;
    sel_a   = sel ? a1 : a0;
    sel_b   = sel ? b1 : b0;
  end

  // The max path has no sign-valid result of its own, so its overflow comes from a_q - b_q.
  always_comb begin
    diff     = a_q - b_q;
    a_sign   = a_q[W-1];
    b_sign   = b_q[W-1];
    r_sign   = alu_result[W-1];
    ovf_flag = 1'b0;
    unique case (op_q)
      2'b00:   ovf_flag = (a_sign == b_sign) && (r_sign != a_sign);
      2'b10:   ovf_flag = (a_sign != b_sign) && (diff[W-1] != a_sign);
      default: ovf_flag = (a_sign != b_sign) && (r_sign != a_sign);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      res0       <= '0;
      res1       <= '0;
      ovf0       <= 1'b0;
      ovf1       <= 1'b0;
      busy       <= 1'b0;
      alu_select <= 2'b00;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            owner_q    <= sel;
            alu_select <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            gnt0       <= ~sel;
            gnt1       <= sel;
            prio_q     <= ~sel;
            busy       <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StCapture;
        end
        StCapture: begin
          if (owner_q) begin
            res1  <= alu_result;
            ovf1  <= ovf_flag;
            done1 <= 1'b1;
          end else begin
            res0  <= alu_result;
            ovf0  <= ovf_flag;
            done0 <= 1'b1;
          end
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: registered ALU model, transaction-level reference compared every cycle,
// plus directed scenarios with hand-computed literals.
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, ovf0, ovf1, busy;
  logic [7:0] res0, res1, alu_a, alu_b, alu_result;
  logic [1:0] alu_select;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1), .ovf0(ovf0), .ovf1(ovf1), .busy(busy),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  // ALU: max picks b when the wrapped difference a-b is negative.
  function automatic logic [7:0] alu_fn(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    case (s)
      2'b00:   return a + b;
      2'b10:   return d[7] ? b : a;
      default: return d;
    endcase
  endfunction

  // Overflow from true signed arithmetic leaving the 8-bit range.
  function automatic logic ovf_fn(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = (s == 2'b00) ? sa + sb : sa - sb;
    return (r > 127) || (r < -128);
  endfunction

  logic [1:0] alu_sel_q;
  logic [7:0] alu_a_q, alu_b_q;
  always @(posedge clk) begin
    alu_sel_q <= alu_select;
    alu_a_q   <= alu_a;
    alu_b_q   <= alu_b;
  end
  assign alu_result = alu_fn(alu_sel_q, alu_a_q, alu_b_q);

  // Reference: an op occupies the ALU for the grant cycle plus two more, results land on the third.
  int         m_left;
  logic       m_prio, m_owner;
  logic [1:0] m_op;
  logic [7:0] m_a, m_b;
  logic       e_gnt0, e_gnt1, e_done0, e_done1, e_ovf0, e_ovf1, e_busy;
  logic [7:0] e_res0, e_res1, e_alu_a, e_alu_b;
  logic [1:0] e_sel;
  logic       m_k;
  assign m_k = (req0 && req1) ? m_prio : req1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0; m_prio <= 1'b0; m_owner <= 1'b0;
      e_gnt0 <= 1'b0; e_gnt1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
      e_res0 <= 8'h00; e_res1 <= 8'h00; e_ovf0 <= 1'b0; e_ovf1 <= 1'b0; e_busy <= 1'b0;
      e_sel <= 2'b00; e_alu_a <= 8'h00; e_alu_b <= 8'h00;
    end else begin
      e_gnt0 <= 1'b0; e_gnt1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
      if (m_left == 2) begin
        m_left <= 1;
      end else if (m_left == 1) begin
        m_left <= 0;
        e_busy <= 1'b0;
        if (m_owner) begin
          e_done1 <= 1'b1; e_res1 <= alu_fn(m_op, m_a, m_b); e_ovf1 <= ovf_fn(m_op, m_a, m_b);
        end else begin
          e_done0 <= 1'b1; e_res0 <= alu_fn(m_op, m_a, m_b); e_ovf0 <= ovf_fn(m_op, m_a, m_b);
        end
      end else if (req0 || req1) begin
        m_left  <= 2;
        m_owner <= m_k;
        m_prio  <= ~m_k;
        m_op    <= m_k ? op1 : op0;
        m_a     <= m_k ? a1 : a0;
        m_b     <= m_k ? b1 : b0;
        e_sel   <= m_k ? op1 : op0;
        e_alu_a <= m_k ? a1 : a0;
        e_alu_b <= m_k ? b1 : b0;
        e_gnt0  <= ~m_k;
        e_gnt1  <= m_k;
        e_busy  <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt0", gnt0, e_gnt0);
      chk("gnt1", gnt1, e_gnt1);
      chk("done0", done0, e_done0);
      chk("done1", done1, e_done1);
      chk("res0", res0, e_res0);
      chk("res1", res1, e_res1);
      chk("ovf0", ovf0, e_ovf0);
      chk("ovf1", ovf1, e_ovf1);
      chk("busy", busy, e_busy);
      chk("alu_select", alu_select, e_sel);
      chk("alu_a", alu_a, e_alu_a);
      chk("alu_b", alu_b, e_alu_b);
      chk("one_gnt", gnt0 & gnt1, 0);
      chk("one_done", done0 & done1, 0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // One op on port p; literal expectations for result and overflow, bounded waits.
  task automatic run_op(input int p, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] xr, input logic xo);
    bit seen;
    if (p == 0) begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
    else begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc();
      seen = (p == 0) ? gnt0 : gnt1;
    end
    if (!seen) chk("gnt_timeout", 0, 1);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc();
      seen = (p == 0) ? done0 : done1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("op_res", (p == 0) ? res0 : res1, xr);
    chk("op_ovf", (p == 0) ? ovf0 : ovf1, xo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    cyc(); cyc();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_res0", res0, 8'h00);
    chk("rst_gnt", {gnt1, gnt0}, 0);

    // Single add on port 0 with exact cycle positions.
    op0 = 2'b00; a0 = 8'h05; b0 = 8'h03; req0 = 1'b1;
    cyc();
    chk("t1_gnt0_c1", gnt0, 1);
    chk("t1_busy_c1", busy, 1);
    req0 = 1'b0;
    cyc();
    chk("t1_busy_c2", busy, 1);
    chk("t1_done0_c2", done0, 0);
    cyc();
    chk("t1_done0_c3", done0, 1);
    chk("t1_res0", res0, 8'h08);
    chk("t1_ovf0", ovf0, 0);
    chk("t1_busy_c3", busy, 0);

    run_op(1, 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1);
    run_op(1, 2'b11, 8'h10, 8'h20, 8'hF0, 1'b0);
    run_op(0, 2'b10, 8'h05, 8'h09, 8'h09, 1'b0);
    run_op(0, 2'b10, 8'h7F, 8'h80, 8'h80, 1'b1);
    run_op(0, 2'b00, 8'h7F, 8'h01, 8'h80, 1'b1);

    // Both ports held high: grants alternate starting from port 0 after reset.
    do_reset();
    op0 = 2'b00; a0 = 8'h01; b0 = 8'h01; op1 = 2'b00; a1 = 8'h02; b1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    cyc();
    chk("t4_gnt0_c1", gnt0, 1);
    chk("t4_gnt1_c1", gnt1, 0);
    cyc(); cyc();
    chk("t4_done0_c3", done0, 1);
    chk("t4_res0", res0, 8'h02);
    cyc();
    chk("t4_gnt1_c4", gnt1, 1);
    cyc(); cyc();
    chk("t4_done1_c6", done1, 1);
    chk("t4_res1", res1, 8'h04);
    cyc();
    chk("t4_gnt0_c7", gnt0, 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) cyc();

    // Reset during CAPTURE drops the op.
    op1 = 2'b00; a1 = 8'h03; b1 = 8'h04; req1 = 1'b1;
    cyc();
    chk("t5_gnt1", gnt1, 1);
    req1 = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t5_done1", done1, 0);
    chk("t5_res1", res1, 8'h00);
    chk("t5_busy", busy, 0);
    chk("t5_alu_a", alu_a, 8'h00);
    cyc();
    chk("t5_no_late_done", done1, 0);
    a0 = 8'h01; b0 = 8'h01; op0 = 2'b00; req0 = 1'b1; req1 = 1'b1;
    cyc();
    chk("t5_gnt0_first", gnt0, 1);
    req0 = 1'b0;
    cyc(); cyc(); cyc();
    chk("t5_gnt1_next", gnt1, 1);
    req1 = 1'b0;
    repeat (3) cyc();

    // Port 1 request arriving during a port 0 op waits for IDLE.
    op0 = 2'b00; a0 = 8'h11; b0 = 8'h22; req0 = 1'b1;
    cyc();
    chk("t6_gnt0", gnt0, 1);
    req0 = 1'b0;
    op1 = 2'b01; a1 = 8'h09; b1 = 8'h02; req1 = 1'b1;
    cyc();
    chk("t6_no_gnt1_busy", gnt1, 0);
    cyc();
    chk("t6_done0", done0, 1);
    chk("t6_res0", res0, 8'h33);
    cyc();
    chk("t6_gnt1", gnt1, 1);
    req1 = 1'b0;
    cyc(); cyc();
    chk("t6_done1", done1, 1);
    chk("t6_res1", res1, 8'h07);
    chk("t6_res0_held", res0, 8'h33);
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
